// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: fetch-stage state encoding and the IEEE double
// value width used on every datapath between fetch and mac.
package spmv_pkg;

    localparam int unsigned VAL_W = 64;

    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage : spmv_pkg

// File: rtl/x_vector_ram.sv
// x-vector storage: simple dual-port RAM, one write port and one registered
// read port with 1-cycle latency. The contents are not reset.
//   clk               rising-edge clock
//   wr_en/addr/data   write port
//   rd_en/rd_addr     read request, data appears on rd_data next cycle
//   rd_data           registered read data
module x_vector_ram
    import spmv_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH - 1)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  val_t              wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output val_t              rd_data
);

    val_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : x_vector_ram

// File: rtl/nz_fetch.sv
// Nonzero fetch stage of the SpMV engine. Accepts a stream of matrix
// nonzeros, looks up x[col], and issues (row, value, x) products to the mac
// two cycles after acceptance, followed by a one-cycle eof after the last.
//   clk, rst                clock, async active-low reset
//   x_wr/x_addr/x_data      x-vector load port (has priority over the stream)
//   nz_valid/nz_ready       nonzero stream handshake
//   nz_val/nz_col           nonzero value and column
//   nz_row_end/nz_last      row and matrix terminators
//   wr/row/v0/v1            product request to the mac
//   eof                     end-of-matrix pulse
//   busy                    matrix in progress
module nz_fetch
    import spmv_pkg::*;
#(
    parameter int unsigned INTERMEDIATOR_DEPTH      = 1024,
    parameter int unsigned LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH - 1),
    parameter int unsigned VECTOR_DEPTH             = 1024,
    parameter int unsigned LOG2_VECTOR_DEPTH        = $clog2(VECTOR_DEPTH - 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                x_wr,
    input  logic [LOG2_VECTOR_DEPTH-1:0]        x_addr,
    input  val_t                                x_data,
    input  logic                                nz_valid,
    output logic                                nz_ready,
    input  val_t                                nz_val,
    input  logic [LOG2_VECTOR_DEPTH-1:0]        nz_col,
    input  logic                                nz_row_end,
    input  logic                                nz_last,
    output logic                                wr,
    output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
    output val_t                                v0,
    output val_t                                v1,
    output logic                                eof,
    output logic                                busy
);

    localparam int unsigned ROW_W = LOG2_INTERMEDIATOR_DEPTH;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(INTERMEDIATOR_DEPTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               flush_done;
    logic [ROW_W-1:0]   row_cnt;
    logic               s1_valid;
    logic               s1_last;
    val_t               s1_val;
    logic [ROW_W-1:0]   s1_row;
    logic               out_last;
    val_t               ram_rd_data;

    // Stream is open in IDLE/RUN unless an x load is using the RAM this cycle
    assign nz_ready = rst && ((state_q == IDLE) || (state_q == RUN)) && !x_wr;
    assign accept   = nz_valid && nz_ready;

    x_vector_ram #(
        .DEPTH  (VECTOR_DEPTH),
        .ADDR_W (LOG2_VECTOR_DEPTH)
    ) u_x_ram (
        .clk     (clk),
        .wr_en   (x_wr),
        .wr_addr (x_addr),
        .wr_data (x_data),
        .rd_en   (accept),
        .rd_addr (nz_col),
        .rd_data (ram_rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; FLUSH ends on the edge after the last product is on wr
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = nz_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept && nz_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (wr && out_last) begin
                    state_d    = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row counter; nz_last also closes the row, and end of matrix clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
        end else if (flush_done) begin
            row_cnt <= '0;
        end else if (accept && (nz_row_end || nz_last)) begin
            row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + ROW_W'(1);
        end
    end

    // Stage 1: aligns value/row with the RAM read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_val   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= nz_last;
                s1_val  <= nz_val;
                s1_row  <= row_cnt;
            end
        end
    end

    // Output stage: data holds when no product is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr       <= 1'b0;
            out_last <= 1'b0;
            row      <= '0;
            v0       <= '0;
            v1       <= '0;
        end else begin
            wr       <= s1_valid;
            out_last <= s1_valid && s1_last;
            if (s1_valid) begin
                row <= s1_row;
                v0  <= s1_val;
                v1  <= ram_rd_data;
            end
        end
    end

    // eof and busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eof  <= 1'b0;
            busy <= 1'b0;
        end else begin
            eof <= flush_done;
            if (flush_done) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end
        end
    end

endmodule : nz_fetch

// File: tb/tb_nz_fetch.sv
// Directed self-checking bench for nz_fetch.
module tb_nz_fetch;

    localparam logic [63:0] X1 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] X2 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] X3 = 64'h4008_0000_0000_0000;
    localparam logic [63:0] X4 = 64'h4010_0000_0000_0000;
    localparam logic [63:0] X5 = 64'h4014_0000_0000_0000;
    localparam logic [63:0] X8 = 64'h4020_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        x_wr;
    logic [9:0]  x_addr;
    logic [63:0] x_data;
    logic        nz_valid;
    logic        nz_ready;
    logic [63:0] nz_val;
    logic [9:0]  nz_col;
    logic        nz_row_end;
    logic        nz_last;
    logic        wr;
    logic [9:0]  row;
    logic [63:0] v0;
    logic [63:0] v1;
    logic        eof;
    logic        busy;

    int total;
    int bad;

    nz_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .x_wr       (x_wr),
        .x_addr     (x_addr),
        .x_data     (x_data),
        .nz_valid   (nz_valid),
        .nz_ready   (nz_ready),
        .nz_val     (nz_val),
        .nz_col     (nz_col),
        .nz_row_end (nz_row_end),
        .nz_last    (nz_last),
        .wr         (wr),
        .row        (row),
        .v0         (v0),
        .v1         (v1),
        .eof        (eof),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nz(input logic v, input logic [63:0] val, input logic [9:0] col,
                            input logic re, input logic last);
        nz_valid   = v;
        nz_val     = val;
        nz_col     = col;
        nz_row_end = re;
        nz_last    = last;
    endtask

    task automatic idle_nz();
        drive_nz(1'b0, 64'd0, 10'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] xs [5];
        int pat [12];
        int in_idx;
        int out_idx;
        int gaps;

        xs  = '{X1, X2, X3, X4, X5};
        pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        total = 0;
        bad   = 0;
        rst    = 1'b0;
        x_wr   = 1'b0;
        x_addr = 10'd0;
        x_data = 64'd0;
        idle_nz();

        // Reset state
        step();
        step();
        chk("rst_wr",    64'(wr),       64'd0);
        chk("rst_eof",   64'(eof),      64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_ready", 64'(nz_ready), 64'd0);
        chk("rst_row",   64'(row),      64'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(nz_ready), 64'd1);

        // Load x[0..4] = 1.0 .. 5.0
        for (int i = 0; i < 5; i++) begin
            x_wr   = 1'b1;
            x_addr = 10'(i);
            x_data = xs[i];
            #1;
            chk($sformatf("load_ready%0d", i), 64'(nz_ready), 64'd0);
            step();
        end
        x_wr = 1'b0;

        // Back-to-back stream at col 4, row_end on #2 and #5 (last)
        for (int s = 0; s < 8; s++) begin
            if (s < 5) drive_nz(1'b1, 64'h1000 + 64'(s), 10'd4, (s == 1) || (s == 4), s == 4);
            else       idle_nz();
            step();
            if (s >= 1 && s <= 5) begin
                chk($sformatf("b2b_wr%0d", s),  64'(wr), 64'd1);
                chk($sformatf("b2b_v0_%0d", s), v0, 64'h1000 + 64'(s - 1));
                chk($sformatf("b2b_v1_%0d", s), v1, X5);
                chk($sformatf("b2b_row%0d", s), 64'(row), (s - 1 >= 2) ? 64'd1 : 64'd0);
            end else begin
                chk($sformatf("b2b_nowr%0d", s), 64'(wr), 64'd0);
            end
            chk($sformatf("b2b_eof%0d", s), 64'(eof), (s == 6) ? 64'd1 : 64'd0);
            if (s == 4 || s == 5) chk($sformatf("b2b_flush_ready%0d", s), 64'(nz_ready), 64'd0);
            if (s == 0) chk("b2b_busy_on", 64'(busy), 64'd1);
            if (s == 6) begin
                chk("b2b_busy_off", 64'(busy), 64'd0);
                chk("b2b_v0_hold",  v0, 64'h1004);
                chk("b2b_row_hold", 64'(row), 64'd1);
            end
        end

        // Single nonzero with nz_last
        drive_nz(1'b1, 64'hABCD, 10'd2, 1'b0, 1'b1);
        step();
        idle_nz();
        chk("last_wr_t1",    64'(wr),       64'd0);
        chk("last_ready_t1", 64'(nz_ready), 64'd0);
        chk("last_busy_t1",  64'(busy),     64'd1);
        step();
        chk("last_wr_t2",  64'(wr),  64'd1);
        chk("last_v0_t2",  v0,       64'hABCD);
        chk("last_v1_t2",  v1,       X3);
        chk("last_row_t2", 64'(row), 64'd0);
        chk("last_eof_t2", 64'(eof), 64'd0);
        step();
        chk("last_wr_t3",    64'(wr),       64'd0);
        chk("last_eof_t3",   64'(eof),      64'd1);
        chk("last_ready_t3", 64'(nz_ready), 64'd1);
        chk("last_busy_t3",  64'(busy),     64'd0);
        step();
        chk("last_eof_t4", 64'(eof), 64'd0);

        // 1025 single-entry rows: row wraps 1023 -> 0
        for (int s = 0; s < 1027; s++) begin
            if (s < 1025) drive_nz(1'b1, 64'(s), 10'd0, 1'b1, s == 1024);
            else          idle_nz();
            step();
            if (s >= 1 && s <= 1025) begin
                chk($sformatf("wrap_wr%0d", s),  64'(wr),  64'd1);
                chk($sformatf("wrap_row%0d", s), 64'(row), 64'((s - 1) % 1024));
            end
            if (s == 1026) begin
                chk("wrap_eof",   64'(eof), 64'd1);
                chk("wrap_nowr",  64'(wr),  64'd0);
            end
        end
        step();

        // Load priority: x_wr to x[3] while a nonzero at col 3 waits
        x_wr   = 1'b1;
        x_addr = 10'd3;
        x_data = X8;
        drive_nz(1'b1, 64'hBEEF, 10'd3, 1'b0, 1'b1);
        #1;
        chk("prio_ready_blocked", 64'(nz_ready), 64'd0);
        step();
        x_wr = 1'b0;
        #1;
        chk("prio_ready_open", 64'(nz_ready), 64'd1);
        chk("prio_wr_e0",      64'(wr),       64'd0);
        step();
        idle_nz();
        chk("prio_wr_e1", 64'(wr), 64'd0);
        step();
        chk("prio_wr_e2", 64'(wr), 64'd1);
        chk("prio_v0",    v0,      64'hBEEF);
        chk("prio_v1",    v1,      X8);
        step();
        chk("prio_eof", 64'(eof), 64'd1);
        step();

        // Reset with two products in flight
        drive_nz(1'b1, 64'hC0, 10'd0, 1'b0, 1'b0);
        step();
        drive_nz(1'b1, 64'hC1, 10'd1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        idle_nz();
        #1;
        chk("mrst_wr",    64'(wr),       64'd0);
        chk("mrst_eof",   64'(eof),      64'd0);
        chk("mrst_row",   64'(row),      64'd0);
        chk("mrst_busy",  64'(busy),     64'd0);
        chk("mrst_ready", 64'(nz_ready), 64'd0);
        step();
        chk("mrst_wr_e1",  64'(wr),  64'd0);
        chk("mrst_eof_e1", 64'(eof), 64'd0);
        step();
        chk("mrst_wr_e2", 64'(wr), 64'd0);
        rst = 1'b1;
        drive_nz(1'b1, 64'hD0, 10'd4, 1'b1, 1'b1);
        step();
        idle_nz();
        chk("post_rst_wr_e0", 64'(wr), 64'd0);
        step();
        chk("post_rst_wr",  64'(wr),  64'd1);
        chk("post_rst_row", 64'(row), 64'd0);
        chk("post_rst_v0",  v0,       64'hD0);
        chk("post_rst_v1",  v1,       X5);
        step();
        chk("post_rst_eof", 64'(eof), 64'd1);
        step();

        // Stall: nz_valid drops for 3 cycles in the middle of a matrix
        in_idx  = 0;
        out_idx = 0;
        gaps    = 0;
        for (int s = 0; s < 12; s++) begin
            if (pat[s] != 0) begin
                drive_nz(1'b1, 64'hE0 + 64'(in_idx), 10'd1, 1'b0, in_idx == 5);
                in_idx++;
            end else begin
                idle_nz();
            end
            step();
            if (s >= 1) begin
                chk($sformatf("stall_wr%0d", s), 64'(wr), 64'(pat[s - 1]));
                if (wr) begin
                    chk($sformatf("stall_v0_%0d", s),  v0,       64'hE0 + 64'(out_idx));
                    chk($sformatf("stall_v1_%0d", s),  v1,       X2);
                    chk($sformatf("stall_row%0d", s),  64'(row), 64'd0);
                    out_idx++;
                end else if (out_idx > 0 && out_idx < 6) begin
                    gaps++;
                end
            end
            chk($sformatf("stall_eof%0d", s), 64'(eof), (s == 10) ? 64'd1 : 64'd0);
        end
        chk("stall_gaps",     64'(gaps),    64'd3);
        chk("stall_products", 64'(out_idx), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nz_fetch
